alu_seq: RTL and testbench

//  Registered, handshaked successor to the combinational ALU. Accepts one operation per

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_iter.sv | 66 ++++++
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and the
// control FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_XNOR = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_ADC  = 4'hC;
  // Opcodes D..F all pass operand A through; OP_PASS names the first of them.
  localparam logic [3:0] OP_PASS = 4'hD;

  // IDLE accepts work; MUL waits for the iterative multiplier.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Operations whose carry flag is meaningful from the adder.
  function automatic logic is_add_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier. A start pulse latches both
// operands; one multiplier bit is consumed per cycle and done is raised
// during the WORD_SIZE-th busy cycle with the full product on prod.
module alu_mul_iter #(
  parameter int WORD_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WORD_SIZE-1:0]     a,
  input  logic [WORD_SIZE-1:0]     b,
  output logic                     done,
  output logic [2*WORD_SIZE-1:0]   prod
);

  localparam int CW = $clog2(WORD_SIZE);

  logic                   busy;
  logic [CW-1:0]          count;
  logic [2*WORD_SIZE-1:0] acc;
  logic [2*WORD_SIZE-1:0] mcand;
  logic [WORD_SIZE-1:0]   mplier;
  logic [2*WORD_SIZE-1:0] partial;
  logic [2*WORD_SIZE-1:0] acc_next;

  // Partial product for the current multiplier bit and the running sum.
  always_comb begin
    partial  = mplier[0] ? mcand : '0;
    acc_next = acc + partial;
  end

  // The final add is presented combinationally so the product is ready
  // on the same cycle done is raised.
  assign done = busy && (count == CW'(WORD_SIZE - 1));
  assign prod = acc_next;

  // Shift-add iteration: accumulate, shift multiplicand left, multiplier right.
  // NOTE: every register in the block sits on the async reset so an abort
  // mid-multiply leaves no stale partial product behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{WORD_SIZE{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU. Single-cycle operations are
// computed combinationally and registered on acceptance; MUL is handed to
// an iterative multiplier and the FSM blocks new work until it finishes.
module alu_seq #(
  parameter int WORD_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] d1,
  input  logic [WORD_SIZE-1:0] d2,
  input  logic [3:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out,
  output logic                 iszero,
  output logic                 iscarry,
  output logic                 isneg,
  output logic                 isovf
);

  import alu_pkg::*;

  localparam int                   SW    = $clog2(WORD_SIZE);
  localparam logic [WORD_SIZE-1:0] W_LIM = WORD_SIZE'(WORD_SIZE);

  state_t state;
  state_t state_next;

  logic                   cflag;
  logic                   in_fire;
  logic                   out_fire;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*WORD_SIZE-1:0] mul_prod;

  logic [WORD_SIZE-1:0]   add_b;
  logic                   add_cin;
  logic [WORD_SIZE:0]     sum;
  logic                   sum_ovf;

  logic                   shift_big;
  logic [SW-1:0]          sh_amt;
  logic [WORD_SIZE-1:0]   shl_res;
  logic [WORD_SIZE-1:0]   shr_res;
  logic signed [WORD_SIZE-1:0] sra_raw;
  logic [WORD_SIZE-1:0]   sra_res;

  logic [WORD_SIZE-1:0]   alu_res;
  logic                   alu_carry;
  logic                   alu_ovf;

  logic                   load;
  logic [WORD_SIZE-1:0]   load_res;
  logic                   load_carry;
  logic                   load_ovf;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: enter MUL on an accepted multiply, leave when it is done.
  always_comb begin
    // NOTE: default first so no path through the case can infer a latch.
    state_next = state;
    case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the output slot frees this cycle.
  always_comb begin
    in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    mul_start = in_ready && in_valid && (opcode == OP_MUL);
  end

  alu_mul_iter #(
    .WORD_SIZE (WORD_SIZE)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (d1),
    .b     (d2),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Shared adder for ADD / SUB / ADC; SUB is d1 + ~d2 + 1 so carry means no borrow.
  always_comb begin
    add_b   = (opcode == OP_SUB) ? ~d2 : d2;
    add_cin = (opcode == OP_SUB) ? 1'b1 : ((opcode == OP_ADC) ? cflag : 1'b0);
    sum     = {1'b0, d1} + {1'b0, add_b} + {{WORD_SIZE{1'b0}}, add_cin};
    sum_ovf = (d1[WORD_SIZE-1] == add_b[WORD_SIZE-1]) &&
              (sum[WORD_SIZE-1] != d1[WORD_SIZE-1]);
  end

  // Shifters look at the whole of d2: any amount >= WORD_SIZE saturates.
  always_comb begin
    shift_big = (d2 >= W_LIM);
    sh_amt    = d2[SW-1:0];
    sra_raw   = $signed(d1) >>> sh_amt;
    shl_res   = shift_big ? '0 : (d1 << sh_amt);
    shr_res   = shift_big ? '0 : (d1 >> sh_amt);
    sra_res   = shift_big ? {WORD_SIZE{d1[WORD_SIZE-1]}} : sra_raw;
  end

  // Single-cycle result select; overflow and carry only from the adder ops.
  always_comb begin
    alu_carry = is_add_op(opcode) ? sum[WORD_SIZE] : 1'b0;
    alu_ovf   = is_add_op(opcode) ? sum_ovf : 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC: alu_res = sum[WORD_SIZE-1:0];
      OP_OR:   alu_res = d1 | d2;
      OP_AND:  alu_res = d1 & d2;
      OP_XOR:  alu_res = d1 ^ d2;
      OP_NOR:  alu_res = ~(d1 | d2);
      OP_NAND: alu_res = ~(d1 & d2);
      OP_XNOR: alu_res = ~(d1 ^ d2);
      OP_SHL:  alu_res = shl_res;
      OP_SHR:  alu_res = shr_res;
      OP_SRA:  alu_res = sra_res;
      // MUL never loads from this path; D..F pass operand A.
      default: alu_res = d1;
    endcase
  end

  // Load source: the multiplier on its final cycle, else an accepted single-cycle op.
  always_comb begin
    load = mul_done || (in_fire && (opcode != OP_MUL));
    if (mul_done) begin
      load_res   = mul_prod[WORD_SIZE-1:0];
      load_carry = |mul_prod[2*WORD_SIZE-1:WORD_SIZE];
      load_ovf   = 1'b0;
    end else begin
      load_res   = alu_res;
      load_carry = alu_carry;
      load_ovf   = alu_ovf;
    end
  end

  // Output register: a new result always wins; otherwise a transfer clears valid
  // while data and flags keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      iszero    <= 1'b0;
      iscarry   <= 1'b0;
      isneg     <= 1'b0;
      isovf     <= 1'b0;
      cflag     <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out       <= load_res;
      iszero    <= (load_res == '0);
      iscarry   <= load_carry;
      isneg     <= load_res[WORD_SIZE-1];
      isovf     <= load_ovf;
      cflag     <= load_carry;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WORD_SIZE = 64).
module tb_alu_seq;

  localparam int W = 64;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, OR_ = 4'h3, AND_ = 4'h4,
                         XOR_ = 4'h5, NOR_ = 4'h6, NAND_ = 4'h7, XNOR_ = 4'h8,
                         SHL = 4'h9, SHR = 4'hA, SRA = 4'hB, ADC = 4'hC, PASS = 4'hE;

  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         iszero;
  logic         iscarry;
  logic         isneg;
  logic         isovf;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WORD_SIZE(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d1        (d1),
    .d2        (d2),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .iszero    (iszero),
    .iscarry   (iscarry),
    .isneg     (isneg),
    .isovf     (isovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one op at a negedge with out_ready high; returns at the next negedge.
  task automatic op1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    opcode   = op;
    d1       = a;
    d2       = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] e_out, input logic e_c,
                           input logic e_n, input logic e_z, input logic e_v);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".out"},   out,       e_out);
    check({tag, ".carry"}, iscarry,   e_c);
    check({tag, ".neg"},   isneg,     e_n);
    check({tag, ".zero"},  iszero,    e_z);
    check({tag, ".ovf"},   isovf,     e_v);
  endtask

  // Wait for a MUL result while driving junk on the inputs; checks latency and in_ready.
  task automatic wait_mul(input string tag);
    int  cycles;
    logic ready_seen;
    cycles     = 1;
    ready_seen = 1'b0;
    in_valid   = 1'b1;
    opcode     = ADD;
    d1         = 64'd9;
    d2         = 64'd9;
    while (!out_valid && cycles < 200) begin
      if (in_ready) ready_seen = 1'b1;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"},   cycles,     W + 1);
    check({tag, ".ready_low"}, ready_seen, 1'b0);
  endtask

  logic [3:0]   t_op  [10];
  logic [W-1:0] t_a   [10];
  logic [W-1:0] t_b   [10];
  logic [W-1:0] t_out [10];
  logic         t_c   [10];

  initial begin
    t_op[0] = ADD;  t_a[0] = 64'd100;                t_b[0] = 64'd23;     t_out[0] = 64'd123;                 t_c[0] = 1'b0;
    t_op[1] = SUB;  t_a[1] = 64'd10;                 t_b[1] = 64'd3;      t_out[1] = 64'd7;                   t_c[1] = 1'b1;
    t_op[2] = XOR_; t_a[2] = 64'hFF;                 t_b[2] = 64'h0F;     t_out[2] = 64'hF0;                  t_c[2] = 1'b0;
    t_op[3] = OR_;  t_a[3] = 64'h100;                t_b[3] = 64'h001;    t_out[3] = 64'h101;                 t_c[3] = 1'b0;
    t_op[4] = SHL;  t_a[4] = 64'd1;                  t_b[4] = 64'd8;      t_out[4] = 64'h100;                 t_c[4] = 1'b0;
    t_op[5] = SHR;  t_a[5] = 64'h8000_0000_0000_0000; t_b[5] = 64'd63;    t_out[5] = 64'd1;                   t_c[5] = 1'b0;
    t_op[6] = SRA;  t_a[6] = 64'hFFFF_FFFF_FFFF_FF00; t_b[6] = 64'd4;     t_out[6] = 64'hFFFF_FFFF_FFFF_FFF0; t_c[6] = 1'b0;
    t_op[7] = AND_; t_a[7] = 64'hABCD;               t_b[7] = 64'h00FF;   t_out[7] = 64'hCD;                  t_c[7] = 1'b0;
    t_op[8] = ADD;  t_a[8] = ONES;                   t_b[8] = 64'd2;      t_out[8] = 64'd1;                   t_c[8] = 1'b1;
    t_op[9] = ADC;  t_a[9] = 64'd5;                  t_b[9] = 64'd6;      t_out[9] = 64'd12;                  t_c[9] = 1'b0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = ADD;
    d1        = '0;
    d2        = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.valid", out_valid, 1'b0);
    check("rst.out",   out,       '0);
    check("rst.flags", {iszero, iscarry, isneg, isovf}, 4'b0000);
    check("rst.ready", in_ready,  1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry chain: all-ones + 1 wraps to zero, then ADC consumes the carry
    op1(ADD, ONES, 64'd1);
    check_res("add_wrap", '0, 1'b1, 1'b0, 1'b1, 1'b0);
    op1(ADC, '0, '0);
    check_res("adc_cin", 64'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Subtraction borrow and signed overflow
    op1(SUB, 64'd5, 64'd7);
    check_res("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    op1(SUB, 64'd7, 64'd5);
    check_res("sub_pos", 64'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    op1(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check_res("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Iterative multiply, junk on inputs while busy must be ignored
    op1(MUL, 64'd3, 64'd5);
    check("mul1.ready_after_accept", in_ready, 1'b0);
    wait_mul("mul1");
    check_res("mul1", 64'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    op1(MUL, 64'h8000_0000_0000_0000, 64'd4);
    wait_mul("mul2");
    check_res("mul2", '0, 1'b1, 1'b0, 1'b1, 1'b0);
    op1(ADC, 64'd1, 64'd1);
    check_res("adc_after_mul", 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Logic ops
    op1(OR_,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    check("or.out",   out, 64'hFFF0_FFF0_FFF0_FFF0);
    op1(AND_,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    check("and.out",  out, 64'hF000_F000_F000_F000);
    op1(XOR_,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    check("xor.out",  out, 64'h0FF0_0FF0_0FF0_0FF0);
    op1(NOR_,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    check("nor.out",  out, 64'h000F_000F_000F_000F);
    op1(NAND_, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    check("nand.out", out, 64'h0FFF_0FFF_0FFF_0FFF);
    op1(XNOR_, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    check_res("xnor", 64'hF00F_F00F_F00F_F00F, 1'b0, 1'b1, 1'b0, 1'b0);
    op1(PASS,  64'h1234_5678_9ABC_DEF0, 64'd7);
    check("pass.out", out, 64'h1234_5678_9ABC_DEF0);

    // Shifts, including amounts beyond the word
    op1(SHL, 64'hFF, 64'd67);
    check_res("shl_big", '0, 1'b0, 1'b0, 1'b1, 1'b0);
    op1(SHR, ONES, 64'd67);
    check("shr_big.out", out, '0);
    op1(SRA, 64'h8000_0000_0000_0000, 64'd67);
    check_res("sra_big", ONES, 1'b0, 1'b1, 1'b0, 1'b0);
    op1(SRA, 64'h4000_0000_0000_0000, 64'd67);
    check("sra_big_pos.out", out, '0);
    op1(SRA, 64'h8000_0000_0000_00F0, 64'd4);
    check("sra4.out", out, 64'hF800_0000_0000_000F);
    op1(SHL, 64'h1234, 64'd4);
    check("shl4.out", out, 64'h12340);

    // Reset in the middle of a multiply; cflag must be cleared too
    op1(ADD, ONES, 64'd1);
    op1(MUL, 64'd6, 64'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.valid", out_valid, 1'b0);
    check("midrst.ready", in_ready,  1'b1);
    check("midrst.out",   out,       '0);
    check("midrst.flags", {iszero, iscarry, isneg, isovf}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op1(ADC, '0, '0);
    check_res("adc_after_rst", '0, 1'b0, 1'b0, 1'b1, 1'b0);
    op1(MUL, 64'd6, 64'd7);
    wait_mul("mul3");
    check_res("mul3", 64'd42, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drain, then backpressure
    @(negedge clk);
    check("drain.valid", out_valid, 1'b0);
    check("drain.out_kept", out, 64'd42);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode    = ADD;
    d1        = 64'd1;
    d2        = 64'd2;
    @(negedge clk);
    opcode = ADD;
    d1     = 64'd10;
    d2     = 64'd20;
    for (int i = 0; i < 5; i++) begin
      check("stall.valid", out_valid, 1'b1);
      check("stall.out",   out,       64'd3);
      check("stall.ready", in_ready,  1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release.out",   out,       64'd30);
    check("release.valid", out_valid, 1'b1);

    // Back-to-back stream: one result per cycle, in order
    for (int k = 0; k < 10; k++) begin
      opcode = t_op[k];
      d1     = t_a[k];
      d2     = t_b[k];
      @(negedge clk);
      check("stream.valid", out_valid, 1'b1);
      check("stream.out",   out,       t_out[k]);
      check("stream.carry", iscarry,   t_c[k]);
      check("stream.ready", in_ready,  1'b1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("tail.valid", out_valid, 1'b0);
    check("tail.out",   out,       64'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
